// File: rtl/spidergon_vc_input_port.sv
// Spidergon router input port: one flit FIFO per virtual channel, across-first
// routing per packet, round-robin offer to the switch allocator, per-VC credit return.
module spidergon_vc_input_port #(
    parameter int NUM_OF_NODES            = 8,
    parameter int NODE_IDENTIFIER         = 0,
    parameter int FLIT_DATA_WIDTH         = 16,
    parameter int NUM_OF_VIRTUAL_CHANNELS = 2,
    parameter int VC_DEPTH                = 4,
    localparam int FLIT_TOTAL_WIDTH = FLIT_DATA_WIDTH + 2,
    localparam int VC_W  = (NUM_OF_VIRTUAL_CHANNELS > 1) ? $clog2(NUM_OF_VIRTUAL_CHANNELS) : 1,
    localparam int CNT_W = $clog2(VC_DEPTH) + 1
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic [FLIT_TOTAL_WIDTH-1:0]                 in_flit,
    input  logic                                        in_valid,
    input  logic [VC_W-1:0]                             in_vc,
    output logic [NUM_OF_VIRTUAL_CHANNELS-1:0]          credit_out,
    output logic [FLIT_TOTAL_WIDTH-1:0]                 out_flit,
    output logic                                        out_valid,
    output logic [VC_W-1:0]                             out_vc,
    output logic [1:0]                                  out_port,
    input  logic                                        out_ready,
    output logic [NUM_OF_VIRTUAL_CHANNELS*CNT_W-1:0]    vc_occupancy,
    output logic                                        err_overflow,
    output logic                                        err_protocol
);

    localparam int NV     = NUM_OF_VIRTUAL_CHANNELS;
    localparam int FTW    = FLIT_TOTAL_WIDTH;
    localparam int DEST_W = $clog2(NUM_OF_NODES);
    localparam int PTR_W  = $clog2(VC_DEPTH);
    localparam int Q      = NUM_OF_NODES / 4;

    localparam logic [1:0] TYPE_TAIL   = 2'b00;
    localparam logic [1:0] TYPE_HEAD   = 2'b01;
    localparam logic [1:0] TYPE_BODY   = 2'b10;
    localparam logic [1:0] TYPE_HEADER = 2'b11;

    localparam logic [1:0] PORT_ANTI_CLOCKWISE = 2'd0;
    localparam logic [1:0] PORT_CLOCKWISE      = 2'd1;
    localparam logic [1:0] PORT_ACROSS         = 2'd2;
    localparam logic [1:0] PORT_STOP           = 2'd3;

    typedef enum logic {ROUTE_IDLE, ROUTE_ROUTED} route_state_t;

    logic [FTW-1:0]   r_mem [NV][VC_DEPTH];
    logic [PTR_W-1:0] r_rd_ptr [NV];
    logic [PTR_W-1:0] r_wr_ptr [NV];
    logic [CNT_W-1:0] r_count [NV];
    route_state_t     r_state [NV];
    logic [1:0]       r_port [NV];
    logic [VC_W-1:0]  r_rr;
    logic [NV-1:0]    r_credit;
    logic             r_err_overflow;
    logic             r_err_protocol;

    logic [FTW-1:0]   w_head_flit [NV];
    logic [1:0]       w_head_type [NV];
    logic [NV-1:0]    w_nonempty;
    logic [NV-1:0]    w_full;
    logic [NV-1:0]    w_discard;
    logic [NV-1:0]    w_eligible;
    logic [NV-1:0]    w_push;
    logic [NV-1:0]    w_pop;
    logic             w_found;
    logic [VC_W-1:0]  w_winner;
    logic             w_fwd_pop;
    logic             w_disc_pop;
    logic             w_push_ok;
    logic             w_proto_err;
    route_state_t     w_state_next [NV];
    logic [1:0]       w_port_next [NV];

    // Across-first: short hops go round the ring, anything farther crosses the diameter.
    function automatic logic [1:0] route_of(input logic [FTW-1:0] flit);
        int rel;
        rel = (int'(flit[FTW-3 -: DEST_W]) + NUM_OF_NODES - NODE_IDENTIFIER) % NUM_OF_NODES;
        if (rel == 0)
            return PORT_STOP;
        else if (rel <= Q)
            return PORT_CLOCKWISE;
        else if (rel >= NUM_OF_NODES - Q)
            return PORT_ANTI_CLOCKWISE;
        else
            return PORT_ACROSS;
    endfunction

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(VC_DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    for (genvar v = 0; v < NV; v++) begin : g_vc
        assign w_head_flit[v] = r_mem[v][r_rd_ptr[v]];
        assign w_head_type[v] = w_head_flit[v][FTW-1 -: 2];
        assign w_nonempty[v]  = (r_count[v] != '0);
        assign w_full[v]      = (r_count[v] == CNT_W'(VC_DEPTH));
        // Body/tail with no open packet is dropped here instead of being offered.
        assign w_discard[v]   = w_nonempty[v] && (r_state[v] == ROUTE_IDLE) &&
                                ((w_head_type[v] == TYPE_BODY) || (w_head_type[v] == TYPE_TAIL));
        assign w_eligible[v]  = w_nonempty[v] && !w_discard[v];
        assign w_push[v]      = w_push_ok && (in_vc == VC_W'(v));
        assign vc_occupancy[v*CNT_W +: CNT_W] = r_count[v];
    end

    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int i = 0; i < NV; i++) begin
            if (!w_found && w_eligible[(int'(r_rr) + i) % NV]) begin
                w_found  = 1'b1;
                w_winner = VC_W'((int'(r_rr) + i) % NV);
            end
        end
    end

    always_comb begin
        out_valid = w_found;
        out_vc    = '0;
        out_flit  = '0;
        out_port  = PORT_ANTI_CLOCKWISE;
        if (w_found) begin
            out_vc   = w_winner;
            out_flit = w_head_flit[w_winner];
            if ((w_head_type[w_winner] == TYPE_HEAD) || (w_head_type[w_winner] == TYPE_HEADER))
                out_port = route_of(w_head_flit[w_winner]);
            else
                out_port = r_port[w_winner];
        end
    end

    // A discard only uses the single pop slot when the allocator is not taking a flit.
    always_comb begin
        w_fwd_pop  = w_found && out_ready;
        w_disc_pop = 1'b0;
        w_pop      = '0;
        if (w_fwd_pop) begin
            w_pop[w_winner] = 1'b1;
        end else begin
            for (int i = 0; i < NV; i++) begin
                if (!w_disc_pop && w_discard[i]) begin
                    w_disc_pop = 1'b1;
                    w_pop[i]   = 1'b1;
                end
            end
        end
    end

    assign w_push_ok = in_valid && (!w_full[in_vc] || w_pop[in_vc]);

    always_comb begin
        for (int v = 0; v < NV; v++) begin
            w_state_next[v] = r_state[v];
            w_port_next[v]  = r_port[v];
        end
        w_proto_err = 1'b0;
        if (w_fwd_pop) begin
            case (w_head_type[w_winner])
                TYPE_HEAD: begin
                    w_proto_err              = (r_state[w_winner] == ROUTE_ROUTED);
                    w_state_next[w_winner]   = ROUTE_ROUTED;
                    w_port_next[w_winner]    = route_of(w_head_flit[w_winner]);
                end
                TYPE_HEADER: begin
                    w_proto_err              = (r_state[w_winner] == ROUTE_ROUTED);
                    w_state_next[w_winner]   = ROUTE_IDLE;
                end
                TYPE_TAIL: begin
                    w_state_next[w_winner]   = ROUTE_IDLE;
                end
                default: ;
            endcase
        end else if (w_disc_pop) begin
            w_proto_err = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int v = 0; v < NV; v++) begin
                r_state[v] <= ROUTE_IDLE;
                r_port[v]  <= PORT_ANTI_CLOCKWISE;
            end
        end else begin
            for (int v = 0; v < NV; v++) begin
                r_state[v] <= w_state_next[v];
                r_port[v]  <= w_port_next[v];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int v = 0; v < NV; v++) begin
                r_rd_ptr[v] <= '0;
                r_wr_ptr[v] <= '0;
                r_count[v]  <= '0;
            end
            r_rr           <= '0;
            r_credit       <= '0;
            r_err_overflow <= 1'b0;
            r_err_protocol <= 1'b0;
        end else begin
            for (int v = 0; v < NV; v++) begin
                if (w_push[v])
                    r_wr_ptr[v] <= next_ptr(r_wr_ptr[v]);
                if (w_pop[v])
                    r_rd_ptr[v] <= next_ptr(r_rd_ptr[v]);
                r_count[v] <= r_count[v] + CNT_W'(w_push[v]) - CNT_W'(w_pop[v]);
            end
            if (w_fwd_pop)
                r_rr <= VC_W'((int'(w_winner) + 1) % NV);
            r_credit <= w_pop;
            if (in_valid && !w_push_ok)
                r_err_overflow <= 1'b1;
            if (w_proto_err)
                r_err_protocol <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok)
            r_mem[in_vc][r_wr_ptr[in_vc]] <= in_flit;
    end

    assign credit_out   = r_credit;
    assign err_overflow = r_err_overflow;
    assign err_protocol = r_err_protocol;

endmodule
